// File: rtl/cache_arb_pkg.sv
// Shared types and default sizing for the cache fill arbiter.
package cache_arb_pkg;

  // IDLE arbitrates; I_FILL/D_FILL stream a block read; D_WRITE issues one write then waits.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } arb_state_e;

  localparam int MEM_LAT_DEF     = 4;
  localparam int BLOCK_WORDS_DEF = 8;
  localparam int ADDR_W_DEF      = 16;
  localparam int DATA_W_DEF      = 16;

  function automatic logic [1:0] owner_of(input arb_state_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Cache-side request/return and memory-side bus of the fill arbiter.
interface cache_fill_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORD_W = 3
);
  logic              i_miss;
  logic [ADDR_W-1:0] i_addr;
  logic              i_data_valid;
  logic [WORD_W-1:0] i_word;
  logic [DATA_W-1:0] i_data;
  logic              i_done;

  logic              d_miss;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_data_valid;
  logic [WORD_W-1:0] d_word;
  logic [DATA_W-1:0] d_data;
  logic              d_done;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  logic              freeze;
  logic [1:0]        owner;

  modport master (
    input  i_miss, i_addr, d_miss, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    output i_data_valid, i_word, i_data, i_done,
    output d_data_valid, d_word, d_data, d_done,
    output mem_en, mem_wr, mem_addr, mem_wdata, freeze, owner
  );

  modport slave (
    output i_miss, i_addr, d_miss, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    input  i_data_valid, i_word, i_data, i_done,
    input  d_data_valid, d_word, d_data, d_done,
    input  mem_en, mem_wr, mem_addr, mem_wdata, freeze, owner
  );
endinterface

// File: rtl/fill_sequencer.sv
// Issue/return/wait counters for one granted transaction; drives the memory request
// and flags completion (last returned word of a fill, or end of the write wait).
module fill_sequencer #(
  parameter  int MEM_LAT     = 4,
  parameter  int BLOCK_WORDS = 8,
  parameter  int ADDR_W      = 16,
  localparam int WORD_W      = $clog2(BLOCK_WORDS),
  localparam int CNT_W       = $clog2(MEM_LAT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_i,
  input  logic              write_i,
  input  logic              rvalid_i,
  input  logic [ADDR_W-2:0] word_addr_i,
  output logic              mem_en_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] ret_cnt_o,
  output logic              done_o
);
  // Extra MSB on issue_cnt marks "whole block issued" so no word is ever reissued.
  logic [WORD_W:0]   issue_cnt_q, issue_cnt_d;
  logic [WORD_W-1:0] ret_cnt_q, ret_cnt_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              issue_en, write_en;

  assign issue_en  = fill_i & ~issue_cnt_q[WORD_W];
  assign write_en  = write_i & (wait_cnt_q == '0);
  assign mem_en_o  = issue_en | write_en;
  assign mem_wr_o  = write_en;
  assign ret_cnt_o = ret_cnt_q;
  assign done_o    = (fill_i & rvalid_i & (ret_cnt_q == WORD_W'(BLOCK_WORDS - 1)))
                   | (write_i & (wait_cnt_q == CNT_W'(MEM_LAT)));

  always_comb begin
    mem_addr_o = '0;
    if (issue_en) begin
      mem_addr_o = {word_addr_i[ADDR_W-2:WORD_W], issue_cnt_q[WORD_W-1:0], 1'b0};
    end else if (write_en) begin
      mem_addr_o = {word_addr_i, 1'b0};
    end
  end

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (done_o || (!fill_i && !write_i)) begin
      issue_cnt_d = '0;
      ret_cnt_d   = '0;
      wait_cnt_d  = '0;
    end else begin
      if (issue_en)          issue_cnt_d = issue_cnt_q + (WORD_W + 1)'(1);
      if (fill_i && rvalid_i) ret_cnt_d  = ret_cnt_q + WORD_W'(1);
      if (write_i)           wait_cnt_d  = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      wait_cnt_q  <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I/D cache misses onto one multi-cycle memory, steers returned words, drives freeze.
// Build option CACHE_ARB_RR_EN: when both misses wait in IDLE, the side not granted last wins.
module cache_fill_arbiter
  import cache_arb_pkg::*;
#(
  parameter int MEM_LAT     = MEM_LAT_DEF,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input logic                  clk,
  input logic                  rst,
  cache_fill_arbiter_if.master bus
);
  localparam int WORD_W = $clog2(BLOCK_WORDS);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-2:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              pick_d;
  logic              fill_act, write_act, seq_done;
  logic [WORD_W-1:0] ret_cnt;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = bus.i_addr[0] ^ bus.d_addr[0];

`ifdef CACHE_ARB_RR_EN
  logic last_d_q, last_d_d;

  assign pick_d = bus.d_miss & ~(bus.i_miss & last_d_q);

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == IDLE && (bus.d_miss || bus.i_miss)) last_d_d = pick_d;
  end

  always_ff @(posedge clk) begin
    if (rst) last_d_q <= 1'b1;
    else     last_d_q <= last_d_d;
  end
`else
  assign pick_d = bus.d_miss;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = bus.d_wr ? D_WRITE : D_FILL;
          addr_d  = bus.d_addr[ADDR_W-1:1];
          wdata_d = bus.d_wdata;
        end else if (bus.i_miss) begin
          state_d = I_FILL;
          addr_d  = bus.i_addr[ADDR_W-1:1];
        end
      end
      default: if (seq_done) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign fill_act  = (state_q == I_FILL) || (state_q == D_FILL);
  assign write_act = (state_q == D_WRITE);

  fill_sequencer #(
    .MEM_LAT    (MEM_LAT),
    .BLOCK_WORDS(BLOCK_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .fill_i     (fill_act),
    .write_i    (write_act),
    .rvalid_i   (bus.mem_rvalid),
    .word_addr_i(addr_q),
    .mem_en_o   (bus.mem_en),
    .mem_wr_o   (bus.mem_wr),
    .mem_addr_o (bus.mem_addr),
    .ret_cnt_o  (ret_cnt),
    .done_o     (seq_done)
  );

  assign bus.mem_wdata = wdata_q;

  // Returned words pass straight through to whichever side owns the fill.
  assign bus.i_data_valid = (state_q == I_FILL) & bus.mem_rvalid;
  assign bus.i_word       = ret_cnt;
  assign bus.i_data       = bus.mem_rdata;
  assign bus.i_done       = (state_q == I_FILL) & seq_done;

  assign bus.d_data_valid = (state_q == D_FILL) & bus.mem_rvalid;
  assign bus.d_word       = ret_cnt;
  assign bus.d_data       = bus.mem_rdata;
  assign bus.d_done       = ((state_q == D_FILL) | write_act) & seq_done;

  // Pending misses freeze the pipeline before their grant so no unfrozen gap appears.
  assign bus.freeze = (state_q != IDLE) | bus.i_miss | bus.d_miss;
  assign bus.owner  = owner_of(state_q);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a transaction-level reference model and a latency-line memory.
`timescale 1ns/1ps
module tb_cache_fill_arbiter;
  import cache_arb_pkg::*;

  localparam int MEM_LAT     = 4;
  localparam int BLOCK_WORDS = 8;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int WORD_W      = 3;
  localparam int K_IF = 1, K_DF = 2, K_DW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_fill_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORD_W(WORD_W)) bus ();

  cache_fill_arbiter #(
    .MEM_LAT(MEM_LAT), .BLOCK_WORDS(BLOCK_WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory: read data appears MEM_LAT cycles after acceptance; reset drops in-flight reads.
  logic              pv [MEM_LAT];
  logic [ADDR_W-1:0] pa [MEM_LAT];
  logic              spur = 1'b0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < MEM_LAT; j++) pv[j] <= 1'b0;
    end else begin
      pv[0] <= bus.mem_en & ~bus.mem_wr;
      pa[0] <= bus.mem_addr;
      for (int j = 1; j < MEM_LAT; j++) begin
        pv[j] <= pv[j-1];
        pa[j] <= pa[j-1];
      end
    end
  end

  always_comb begin
    bus.mem_rvalid = pv[MEM_LAT-1] | spur;
    if (pv[MEM_LAT-1]) bus.mem_rdata = mem_word(pa[MEM_LAT-1]);
    else if (spur)     bus.mem_rdata = 16'hDEAD;
    else               bus.mem_rdata = 16'h0000;
  end

  // Reference model: one granted transaction at a time, timed from its grant cycle.
  bit                m_busy = 1'b0;
  bit                m_last_d = 1'b1;
  bit                take_d;
  int                m_kind = 0;
  int                m_t0 = 0;
  int                m_tend = 0;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;

  always @(posedge clk) begin
    if (rst) begin
      m_busy   = 1'b0;
      m_last_d = 1'b1;
    end else if (m_busy) begin
      if (cyc == m_tend) m_busy = 1'b0;
    end else if (bus.i_miss || bus.d_miss) begin
`ifdef CACHE_ARB_RR_EN
      take_d = bus.d_miss && !(bus.i_miss && m_last_d);
`else
      take_d = bus.d_miss;
`endif
      m_last_d = take_d;
      m_busy   = 1'b1;
      m_t0     = cyc;
      if (take_d) begin
        m_kind  = bus.d_wr ? K_DW : K_DF;
        m_addr  = bus.d_addr;
        m_wdata = bus.d_wdata;
      end else begin
        m_kind = K_IF;
        m_addr = bus.i_addr;
      end
      m_tend = cyc + ((m_kind == K_DW) ? 1 + MEM_LAT : BLOCK_WORDS + MEM_LAT);
    end
    cyc++;
  end

  // Compare process plus observation records used by the literal checks.
  int                k, w;
  bit                e_fill, e_wr, e_rv;
  logic [ADDR_W-1:0] base;
  int                obs_n_issue, obs_n_wr, obs_i_valid_n, obs_d_valid_n;
  logic [ADDR_W-1:0] obs_first_addr, obs_last_addr, obs_wr_addr;
  logic [DATA_W-1:0] obs_wr_data;

  always @(negedge clk) begin
    if (!rst) begin
      e_fill = m_busy && (m_kind != K_DW);
      e_wr   = m_busy && (m_kind == K_DW);
      k      = cyc - m_t0;
      w      = k - 1 - MEM_LAT;
      e_rv   = e_fill && (k >= 1 + MEM_LAT) && (k <= BLOCK_WORDS + MEM_LAT);
      base   = m_addr & ~16'(2 * BLOCK_WORDS - 1);
      chk("freeze", 32'(bus.freeze), 32'(m_busy | bus.i_miss | bus.d_miss));
      chk("owner", 32'(bus.owner), m_busy ? 32'(m_kind) : 32'(0));
      chk("mem_en", 32'(bus.mem_en),
          32'((e_fill && k >= 1 && k <= BLOCK_WORDS) || (e_wr && k == 1)));
      chk("mem_wr", 32'(bus.mem_wr), 32'(e_wr && k == 1));
      if (e_fill && k >= 1 && k <= BLOCK_WORDS)
        chk("mem_addr_rd", 32'(bus.mem_addr), 32'(base) + 32'(2 * (k - 1)));
      if (e_wr && k == 1) begin
        chk("mem_addr_wr", 32'(bus.mem_addr), 32'({m_addr[15:1], 1'b0}));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
      end
      chk("i_data_valid", 32'(bus.i_data_valid), 32'(e_rv && m_kind == K_IF));
      chk("d_data_valid", 32'(bus.d_data_valid), 32'(e_rv && m_kind == K_DF));
      chk("i_done", 32'(bus.i_done), 32'(m_busy && m_kind == K_IF && cyc == m_tend));
      chk("d_done", 32'(bus.d_done), 32'(m_busy && m_kind != K_IF && cyc == m_tend));
      if (e_rv && m_kind == K_IF) begin
        chk("i_word", 32'(bus.i_word), 32'(w));
        chk("i_data", 32'(bus.i_data), 32'(mem_word(16'(32'(base) + 32'(2 * w)))));
      end
      if (e_rv && m_kind == K_DF) begin
        chk("d_word", 32'(bus.d_word), 32'(w));
        chk("d_data", 32'(bus.d_data), 32'(mem_word(16'(32'(base) + 32'(2 * w)))));
      end
      if (bus.mem_en && !bus.mem_wr) begin
        if (obs_n_issue == 0) obs_first_addr = bus.mem_addr;
        obs_last_addr = bus.mem_addr;
        obs_n_issue++;
      end
      if (bus.mem_en && bus.mem_wr) begin
        obs_wr_addr = bus.mem_addr;
        obs_wr_data = bus.mem_wdata;
        obs_n_wr++;
      end
      if (bus.i_data_valid) obs_i_valid_n++;
      if (bus.d_data_valid) obs_d_valid_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_n_issue = 0; obs_n_wr = 0; obs_i_valid_n = 0; obs_d_valid_n = 0;
    obs_first_addr = '0; obs_last_addr = '0; obs_wr_addr = '0; obs_wr_data = '0;
  endtask

  // Waits (bounded) for a done pulse, returns its cycle, then steps to just after the next edge.
  task automatic wait_done(input bit is_d, output int dc);
    bit found;
    found = 1'b0;
    dc = -1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (is_d ? bus.d_done : bus.i_done) begin
        found = 1'b1;
        dc = cyc;
        break;
      end
    end
    chk(is_d ? "d_done_seen" : "i_done_seen", 32'(found), 32'(1));
    tick();
  endtask

  int t, dc1, dc2;
  bit seen;

  initial begin
    rst = 1'b1;
    bus.i_miss = 1'b0; bus.i_addr = '0;
    bus.d_miss = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    clear_obs();
    tick(); tick();
    bus.i_miss = 1'b1;
    @(negedge clk);
    chk("freeze_in_reset_with_miss", 32'(bus.freeze), 32'(1));
    tick();
    bus.i_miss = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_owner", 32'(bus.owner), 32'(0));
    chk("reset_mem_en", 32'(bus.mem_en), 32'(0));
    chk("reset_freeze", 32'(bus.freeze), 32'(0));
    tick();

    // I fill at 0x1234
    clear_obs();
    bus.i_addr = 16'h1234; bus.i_miss = 1'b1; t = cyc;
    tick();
    bus.i_addr = 16'hFFFF;
    wait_done(1'b0, dc1);
    bus.i_miss = 1'b0;
    chk("ifill_done_cycle", 32'(dc1), 32'(t + 12));
    chk("ifill_first_addr", 32'(obs_first_addr), 32'h1230);
    chk("ifill_last_addr", 32'(obs_last_addr), 32'h123E);
    chk("ifill_issue_count", 32'(obs_n_issue), 32'(8));
    chk("ifill_words", 32'(obs_i_valid_n), 32'(8));

    // Spurious rvalid while idle
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();

    // D fill at 0x0046
    clear_obs();
    bus.d_addr = 16'h0046; bus.d_wr = 1'b0; bus.d_miss = 1'b1; t = cyc;
    wait_done(1'b1, dc1);
    bus.d_miss = 1'b0;
    chk("dfill_done_cycle", 32'(dc1), 32'(t + 12));
    chk("dfill_first_addr", 32'(obs_first_addr), 32'h0040);
    chk("dfill_last_addr", 32'(obs_last_addr), 32'h004E);
    chk("dfill_no_i_valid", 32'(obs_i_valid_n), 32'(0));
    chk("dfill_words", 32'(obs_d_valid_n), 32'(8));
    tick();

    // D write 0x2002 / 0xBEEF with spurious rvalid during the wait
    clear_obs();
    bus.d_addr = 16'h2002; bus.d_wdata = 16'hBEEF; bus.d_wr = 1'b1; bus.d_miss = 1'b1; t = cyc;
    tick();
    bus.d_addr = 16'h0F0E; bus.d_wdata = 16'h1234;
    tick();
    spur = 1'b1;
    tick(); tick();
    spur = 1'b0;
    wait_done(1'b1, dc1);
    bus.d_miss = 1'b0;
    chk("dwrite_done_cycle", 32'(dc1), 32'(t + 5));
    chk("dwrite_addr", 32'(obs_wr_addr), 32'h2002);
    chk("dwrite_data", 32'(obs_wr_data), 32'hBEEF);
    chk("dwrite_count", 32'(obs_n_wr), 32'(1));
    chk("dwrite_no_d_valid", 32'(obs_d_valid_n), 32'(0));
    tick();

    // Simultaneous I fill and D write
    bus.i_addr = 16'h0300; bus.i_miss = 1'b1;
    bus.d_addr = 16'h0402; bus.d_wdata = 16'h1111; bus.d_wr = 1'b1; bus.d_miss = 1'b1;
    t = cyc;
`ifdef CACHE_ARB_RR_EN
    wait_done(1'b0, dc1);
    bus.i_miss = 1'b0;
    wait_done(1'b1, dc2);
    bus.d_miss = 1'b0;
    chk("pair_i_first_done", 32'(dc1), 32'(t + 12));
    chk("pair_d_second_done", 32'(dc2), 32'(t + 18));
`else
    wait_done(1'b1, dc1);
    bus.d_miss = 1'b0;
    wait_done(1'b0, dc2);
    bus.i_miss = 1'b0;
    chk("pair_d_first_done", 32'(dc1), 32'(t + 5));
    chk("pair_i_second_done", 32'(dc2), 32'(t + 18));
`endif
    tick();

    // Reset on the third returned word of a fill, then a fresh fill
    bus.i_addr = 16'h5678; bus.i_miss = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.i_data_valid && bus.i_word == 3'd1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_test_word1_seen", 32'(seen), 32'(1));
    tick();
    rst = 1'b1; bus.i_miss = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_owner", 32'(bus.owner), 32'(0));
    chk("post_rst_mem_en", 32'(bus.mem_en), 32'(0));
    chk("post_rst_freeze", 32'(bus.freeze), 32'(0));
    chk("post_rst_i_valid", 32'(bus.i_data_valid), 32'(0));
    tick();
    clear_obs();
    bus.i_addr = 16'h0A1C; bus.i_miss = 1'b1; t = cyc;
    wait_done(1'b0, dc1);
    bus.i_miss = 1'b0;
    chk("refill_done_cycle", 32'(dc1), 32'(t + 12));
    chk("refill_first_addr", 32'(obs_first_addr), 32'h0A10);
    chk("refill_words", 32'(obs_i_valid_n), 32'(8));
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
